idwt_1d_lift: RTL and testbench

- Inverse 1-D single-level integer lifting wavelet transform (5/3-style).
- Consumes (low, high) coefficient pairs produced by our forward DWT stage and reconstructs the original 8-bit sample stream, emitted in order x[0], x[1], ….
- Sits at the synthesis end of the codec pipeline. Cascade two instances for 2-level reconstruction.
- Valid/ready handshake on both sides. Frames are delimited by s_last.

---
 rtl/dwt_pkg.sv | 17 +
 rtl/idwt_lift_alu.sv | 50 +++++
 rtl/idwt_1d_lift.sv | 142 ++++++++++++++
 tb/tb_idwt_1d_lift.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/dwt_pkg.sv
// Constants shared by the forward and inverse 5/3 lifting stages so the
// two ends round identically and inversion is bit-exact.
package dwt_pkg;
    localparam int DATA_W_DEF = 8;
    localparam int RND_EVEN   = 2;
    localparam int SHIFT_EVEN = 2;
    localparam int SHIFT_ODD  = 1;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_FILL = 3'd1,
        ST_EVEN = 3'd2,
        ST_ODD  = 3'd3,
        ST_TE   = 3'd4,
        ST_TO   = 3'd5
    } state_t;
endpackage

// File: rtl/idwt_lift_alu.sv
// Combinational lifting terms of the inverse 5/3 transform: even update
// (undo the forward update step) and odd predict (undo the forward predict).
module idwt_lift_alu
    import dwt_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic signed [DATA_W-1:0] s_i,
    input  logic signed [DATA_W-1:0] d_a_i,
    input  logic signed [DATA_W-1:0] d_b_i,
    input  logic signed [DATA_W-1:0] d_i,
    input  logic signed [DATA_W-1:0] e_a_i,
    input  logic signed [DATA_W-1:0] e_b_i,
    output logic signed [DATA_W-1:0] even_o,
    output logic signed [DATA_W-1:0] odd_o
);

    // s - ((da + db + 2) >>> 2); the sum cannot overflow in DATA_W+2 bits.
    function automatic logic signed [DATA_W-1:0] even_update(
        input logic signed [DATA_W-1:0] s,
        input logic signed [DATA_W-1:0] da,
        input logic signed [DATA_W-1:0] db
    );
        logic signed [DATA_W+1:0] sum;
        logic signed [DATA_W+1:0] sh;
        logic signed [DATA_W-1:0] t;
        sum = (DATA_W+2)'(da) + (DATA_W+2)'(db) + (DATA_W+2)'(RND_EVEN);
        sh  = sum >>> SHIFT_EVEN;
        t   = sh[DATA_W-1:0];
        return s - t;
    endfunction

    function automatic logic signed [DATA_W-1:0] odd_predict(
        input logic signed [DATA_W-1:0] d,
        input logic signed [DATA_W-1:0] ea,
        input logic signed [DATA_W-1:0] eb
    );
        logic signed [DATA_W:0]   sum;
        logic signed [DATA_W:0]   sh;
        logic signed [DATA_W-1:0] t;
        sum = (DATA_W+1)'(ea) + (DATA_W+1)'(eb);
        sh  = sum >>> SHIFT_ODD;
        t   = sh[DATA_W-1:0];
        return d + t;
    endfunction

    assign even_o = even_update(s_i, d_a_i, d_b_i);
    assign odd_o  = odd_predict(d_i, e_a_i, e_b_i);

endmodule

// File: rtl/idwt_1d_lift.sv
// Inverse 1-D single-level 5/3 integer lifting: (low, high) pairs in,
// reconstructed samples x[0], x[1], ... out, with valid/ready on both sides.
module idwt_1d_lift
    import dwt_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic                     sys_clk,
    input  logic                     sys_rst,
    input  logic                     s_valid,
    output logic                     s_ready,
    input  logic signed [DATA_W-1:0] s_low,
    input  logic signed [DATA_W-1:0] s_high,
    input  logic                     s_last,
    output logic                     m_valid,
    input  logic                     m_ready,
    output logic signed [DATA_W-1:0] m_data,
    output logic                     m_last,
    output logic                     busy
);

    state_t                   state_q;
    logic signed [DATA_W-1:0] e_prev_q;
    logic signed [DATA_W-1:0] d_prev_q;
    logic signed [DATA_W-1:0] e_new_q;
    logic signed [DATA_W-1:0] d_new_q;
    logic                     last_seen_q;
    logic                     s_ready_q;
    logic                     m_valid_q;
    logic signed [DATA_W-1:0] m_data_q;
    logic                     m_last_q;

    logic signed [DATA_W-1:0] alu_da;
    logic signed [DATA_W-1:0] alu_eb;
    logic signed [DATA_W-1:0] even_w;
    logic signed [DATA_W-1:0] odd_w;
    logic                     in_xfer;
    logic                     out_xfer;

    // First pair mirrors d[-1] = d[0]; the tail odd sample mirrors e[N] = e[N-1].
    assign alu_da = (state_q == ST_IDLE) ? s_high : d_prev_q;
    assign alu_eb = (state_q == ST_TE) ? e_prev_q : e_new_q;

    idwt_lift_alu #(
        .DATA_W (DATA_W)
    ) u_alu (
        .s_i    (s_low),
        .d_a_i  (alu_da),
        .d_b_i  (s_high),
        .d_i    (d_prev_q),
        .e_a_i  (e_prev_q),
        .e_b_i  (alu_eb),
        .even_o (even_w),
        .odd_o  (odd_w)
    );

    assign in_xfer  = s_valid & s_ready_q;
    assign out_xfer = m_valid_q & m_ready;

    // Outputs are loaded with the value belonging to the state being entered.
    always_ff @(posedge sys_clk or negedge sys_rst) begin
        if (!sys_rst) begin
            state_q     <= ST_IDLE;
            e_prev_q    <= '0;
            d_prev_q    <= '0;
            e_new_q     <= '0;
            d_new_q     <= '0;
            last_seen_q <= 1'b0;
            s_ready_q   <= 1'b1;
            m_valid_q   <= 1'b0;
            m_data_q    <= '0;
            m_last_q    <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: if (in_xfer) begin
                    e_prev_q <= even_w;
                    d_prev_q <= s_high;
                    if (s_last) begin
                        state_q   <= ST_TE;
                        s_ready_q <= 1'b0;
                        m_valid_q <= 1'b1;
                        m_data_q  <= even_w;
                    end else begin
                        state_q <= ST_FILL;
                    end
                end
                ST_FILL: if (in_xfer) begin
                    e_new_q     <= even_w;
                    d_new_q     <= s_high;
                    last_seen_q <= s_last;
                    state_q     <= ST_EVEN;
                    s_ready_q   <= 1'b0;
                    m_valid_q   <= 1'b1;
                    m_data_q    <= e_prev_q;
                end
                ST_EVEN: if (out_xfer) begin
                    state_q  <= ST_ODD;
                    m_data_q <= odd_w;
                end
                ST_ODD: if (out_xfer) begin
                    e_prev_q <= e_new_q;
                    d_prev_q <= d_new_q;
                    if (last_seen_q) begin
                        state_q  <= ST_TE;
                        m_data_q <= e_new_q;
                    end else begin
                        state_q   <= ST_FILL;
                        s_ready_q <= 1'b1;
                        m_valid_q <= 1'b0;
                        m_data_q  <= '0;
                    end
                end
                ST_TE: if (out_xfer) begin
                    state_q  <= ST_TO;
                    m_data_q <= odd_w;
                    m_last_q <= 1'b1;
                end
                ST_TO: if (out_xfer) begin
                    state_q   <= ST_IDLE;
                    s_ready_q <= 1'b1;
                    m_valid_q <= 1'b0;
                    m_data_q  <= '0;
                    m_last_q  <= 1'b0;
                end
                default: begin
                    state_q   <= ST_IDLE;
                    s_ready_q <= 1'b1;
                    m_valid_q <= 1'b0;
                    m_data_q  <= '0;
                    m_last_q  <= 1'b0;
                end
            endcase
        end
    end

    assign s_ready = s_ready_q;
    assign m_valid = m_valid_q;
    assign m_data  = m_data_q;
    assign m_last  = m_last_q;
    assign busy    = (state_q != ST_IDLE);

endmodule

// File: tb/tb_idwt_1d_lift.sv
// Bench for idwt_1d_lift: fixed vectors, hand-built corner sequences and
// random frames passed through a forward 5/3 model and back.
module tb_idwt_1d_lift;
    localparam int W = 8;

    logic                sys_clk = 1'b0;
    logic                sys_rst = 1'b0;
    logic                s_valid = 1'b0;
    logic                s_ready;
    logic signed [W-1:0] s_low  = '0;
    logic signed [W-1:0] s_high = '0;
    logic                s_last = 1'b0;
    logic                m_valid;
    logic                m_ready = 1'b0;
    logic signed [W-1:0] m_data;
    logic                m_last;
    logic                busy;

    idwt_1d_lift #(.DATA_W(W)) dut (
        .sys_clk (sys_clk),
        .sys_rst (sys_rst),
        .s_valid (s_valid),
        .s_ready (s_ready),
        .s_low   (s_low),
        .s_high  (s_high),
        .s_last  (s_last),
        .m_valid (m_valid),
        .m_ready (m_ready),
        .m_data  (m_data),
        .m_last  (m_last),
        .busy    (busy)
    );

    always #5 sys_clk = ~sys_clk;

    int n_chk  = 0;
    int n_pass = 0;

    task automatic check(input string nm, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    endtask

    function automatic logic signed [W-1:0] w8(input int v);
        return v[W-1:0];
    endfunction

    // Current frame: pairs to send and the samples they must reconstruct.
    logic signed [W-1:0] lo_a[64];
    logic signed [W-1:0] hi_a[64];
    logic signed [W-1:0] x_a[128];
    int np;
    bit gaps;

    typedef struct {
        int n;
        int lo[2];
        int hi[2];
        int x[4];
    } vec_t;
    vec_t tbl[4];

    task automatic set_vec(input int i, input int n, input int l0, input int l1,
                           input int h0, input int h1, input int x0, input int x1,
                           input int x2, input int x3);
        tbl[i].n = n;
        tbl[i].lo[0] = l0; tbl[i].lo[1] = l1;
        tbl[i].hi[0] = h0; tbl[i].hi[1] = h1;
        tbl[i].x[0] = x0; tbl[i].x[1] = x1; tbl[i].x[2] = x2; tbl[i].x[3] = x3;
    endtask

    task automatic load_vec(input int i);
        np = tbl[i].n;
        for (int k = 0; k < 2; k++) begin
            lo_a[k] = w8(tbl[i].lo[k]);
            hi_a[k] = w8(tbl[i].hi[k]);
        end
        for (int k = 0; k < 4; k++) x_a[k] = w8(tbl[i].x[k]);
    endtask

    // Forward 5/3 lifting of x_a into (lo_a, hi_a), symmetric extension, mod 2^8.
    task automatic forward_dwt(input int n);
        int d[64];
        for (int k = 0; k < n; k++) begin
            int xe0, xe1;
            xe0 = int'(x_a[2*k]);
            xe1 = (k + 1 < n) ? int'(x_a[2*k+2]) : xe0;
            d[k] = int'(w8(int'(x_a[2*k+1]) - ((xe0 + xe1) >>> 1)));
            hi_a[k] = w8(d[k]);
        end
        for (int k = 0; k < n; k++) begin
            int dm;
            dm = (k == 0) ? d[0] : d[k-1];
            lo_a[k] = w8(int'(x_a[2*k]) + ((dm + d[k] + 2) >>> 2));
        end
        np = n;
    endtask

    task automatic drive_pairs();
        for (int i = 0; i < np; i++) begin
            int cyc;
            bit acc;
            cyc = 0;
            acc = 1'b0;
            if (gaps) begin
                while ($urandom_range(0, 2) == 0) begin
                    s_valid = 1'b0;
                    @(negedge sys_clk);
                end
            end
            s_valid = 1'b1;
            s_low   = lo_a[i];
            s_high  = hi_a[i];
            s_last  = (i == np - 1);
            while (!acc && cyc < 2000) begin
                acc = s_ready;
                @(negedge sys_clk);
                cyc++;
            end
            if (!acc) begin
                check("in_timeout", 0, 1);
                break;
            end
        end
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    task automatic collect(input int nout);
        int k, cyc;
        bit prev_stall;
        int prev_data, prev_last;
        k = 0; cyc = 0; prev_stall = 0; prev_data = 0; prev_last = 0;
        while (k < nout && cyc < 3000) begin
            m_ready = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
            if (m_valid) begin
                if (prev_stall) begin
                    check("hold_data", int'(m_data), prev_data);
                    check("hold_last", int'(m_last), prev_last);
                end
                if (m_ready) begin
                    check("data", int'(m_data), int'(x_a[k]));
                    check("last", int'(m_last), int'(k == nout - 1));
                    k++;
                end
                prev_stall = !m_ready;
                prev_data  = int'(m_data);
                prev_last  = int'(m_last);
            end else begin
                if (cyc % 8 == 0) check("idle_data_zero", int'(m_data), 0);
                prev_stall = 0;
            end
            @(negedge sys_clk);
            cyc++;
        end
        if (k < nout) check("out_timeout", k, nout);
        m_ready = 1'b0;
    endtask

    task automatic run_frame();
        fork
            drive_pairs();
            collect(2 * np);
        join
    endtask

    initial begin
        int wait_cyc;
        set_vec(0, 2, 10, 20, 4, -2, 8, 17, 19, 17);
        set_vec(1, 1, 5, 0, 3, 0, 3, 6, 0, 0);
        set_vec(2, 1, 127, 0, -128, 0, -65, 63, 0, 0);
        set_vec(3, 2, -5, 0, 7, 7, -9, 0, -4, 3);

        repeat (3) @(negedge sys_clk);
        check("rst_m_valid", int'(m_valid), 0);
        check("rst_m_data", int'(m_data), 0);
        check("rst_m_last", int'(m_last), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_s_ready", int'(s_ready), 1);
        sys_rst = 1'b1;
        @(negedge sys_clk);

        gaps = 0;
        for (int i = 0; i < 4; i++) begin
            load_vec(i);
            run_frame();
            check("busy_after_frame", int'(busy), 0);
        end

        // Backpressure held in ST_EVEN, plus first-output latency.
        load_vec(0);
        fork
            drive_pairs();
            begin
                m_ready = 1'b0;
                wait_cyc = 0;
                while (!m_valid && wait_cyc < 20) begin
                    @(negedge sys_clk);
                    wait_cyc++;
                end
                check("first_out_latency", wait_cyc, 2);
                for (int c = 0; c < 5; c++) begin
                    check("bp_data", int'(m_data), 8);
                    check("bp_s_ready", int'(s_ready), 0);
                    check("bp_m_valid", int'(m_valid), 1);
                    @(negedge sys_clk);
                end
                collect(4);
            end
        join

        // Asynchronous reset while ST_ODD is presenting its sample.
        load_vec(0);
        fork
            drive_pairs();
            begin
                wait_cyc = 0;
                while (!m_valid && wait_cyc < 20) begin
                    @(negedge sys_clk);
                    wait_cyc++;
                end
                m_ready = 1'b1;
                check("rst_seq_even", int'(m_data), 8);
                @(negedge sys_clk);
                m_ready = 1'b0;
                check("rst_seq_odd", int'(m_data), 17);
                #2;
                sys_rst = 1'b0;
                #1;
                check("async_m_valid", int'(m_valid), 0);
                check("async_m_data", int'(m_data), 0);
                check("async_busy", int'(busy), 0);
                check("async_s_ready", int'(s_ready), 1);
            end
        join
        repeat (2) @(negedge sys_clk);
        check("held_rst_m_valid", int'(m_valid), 0);
        sys_rst = 1'b1;
        load_vec(0);
        run_frame();

        // Random round trips through the forward transform model.
        gaps = 1;
        for (int f = 0; f < 6; f++) begin
            for (int k = 0; k < 32; k++) x_a[k] = w8(int'($urandom));
            forward_dwt(16);
            run_frame();
            repeat (2) @(negedge sys_clk);
            check("busy_after_rand", int'(busy), 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
